mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates an instruction-fetch port and a load/store port onto a
// single byte-wide synchronous RAM.
//
// A transaction moves n bytes (byte = 1, half = 2, word = 4, fetch = 4) one
// byte per cycle at consecutive addresses, with 32-bit address wrap-around.
// MEM has priority over IF. Once granted, a transaction runs to completion;
// the only exception is a fetch cancelled by if_flush.
//
// Valid/ready handshake: a requester raises *_req and holds its address and
// data stable until it sees the one-cycle *_ack pulse. Read data is valid in
// the ack cycle and is held until the next ack of the same owner. The request
// is never re-granted in its own ack cycle, because arbitration only happens
// in IDLE and the FSM leaves the ack cycle for IDLE.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   if_req/if_addr        fetch request and byte address
//   if_flush              cancels a pending or in-flight fetch
//   if_ack/if_data        fetch completion pulse and little-endian word
//   mem_req/mem_we/mem_sel/mem_addr/mem_wdata   load/store request
//   mem_ack/mem_rdata     load/store completion pulse and zero-extended data
//   stallreq_if/mem       combinational stall requests to the pipeline
//   ram_a/ram_wr/ram_dout RAM address, write strobe and write byte
//   ram_din               RAM read byte (one-cycle read latency)
//   dbg_state_o           FSM state: 0 = IDLE, 1 = READ, 2 = WRITE
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [2:0]  n_q, n_d;        // bytes in this transaction
    logic [2:0]  cnt_q, cnt_d;    // cycles since grant, 0 = first RAM cycle
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;    // read assembly buffer
    logic [31:0] ram_a_q, ram_a_d;
    logic        ram_wr_q, ram_wr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [2:0]  last_rd;         // read ack cycle: n+1 after the first RAM cycle
    logic [1:0]  rd_idx;          // byte landing on ram_din this cycle
    logic [1:0]  wr_idx;          // byte to drive in the next write cycle

    assign last_rd = n_q + 3'd1;
    assign rd_idx  = 2'(cnt_q - 3'd1);
    assign wr_idx  = 2'(cnt_q + 3'd1);

    function automatic logic [2:0] size_to_n(input logic [1:0] sel);
        case (sel)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            n_q         <= 3'd0;
            cnt_q       <= 3'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            ram_a_q     <= 32'd0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            S_IDLE: begin
                // The RAM address/strobe/byte for the first cycle are loaded
                // at the grant edge so the RAM sees them in cycle G+1.
                if (mem_req) begin
                    owner_d = OWN_MEM;
                    n_d     = size_to_n(mem_sel);
                    cnt_d   = 3'd0;
                    ram_a_d = mem_addr;
                    buf_d   = 32'd0;
                    wdata_d = mem_wdata;
                    if (mem_we) begin
                        state_d    = S_WRITE;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d = S_READ;
                    end
                end else if (if_req && !if_flush) begin
                    owner_d = OWN_IF;
                    n_d     = 3'd4;
                    cnt_d   = 3'd0;
                    ram_a_d = if_addr;
                    buf_d   = 32'd0;
                    state_d = S_READ;
                end
            end

            S_READ: begin
                if (owner_q == OWN_IF && if_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < n_q - 3'd1) begin
                        ram_a_d = ram_a_q + 32'd1;
                    end
                    // Data for the address of cycle c arrives in cycle c+1.
                    if (cnt_q != 3'd0 && cnt_q <= n_q) begin
                        buf_d[{rd_idx, 3'b000} +: 8] = ram_din;
                    end
                    // Publish the completed word so it is valid in the ack cycle.
                    if (cnt_q == n_q) begin
                        if (owner_q == OWN_IF) begin
                            if_data_d = buf_d;
                        end else begin
                            mem_rdata_d = buf_d;
                        end
                    end
                    if (cnt_q == last_rd) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < n_q - 3'd1) begin
                    ram_wr_d   = 1'b1;
                    ram_a_d    = ram_a_q + 32'd1;
                    ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
                end
                if (cnt_q == n_q) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign if_ack  = (state_q == S_READ) && (owner_q == OWN_IF) && (cnt_q == last_rd);
    assign mem_ack = ((state_q == S_READ) && (owner_q == OWN_MEM) && (cnt_q == last_rd)) ||
                     ((state_q == S_WRITE) && (cnt_q == n_q));

    assign stallreq_if  = if_req & ~if_flush & ~if_ack;
    assign stallreq_mem = mem_req & ~mem_ack;

    assign if_data     = if_data_q;
    assign mem_rdata   = mem_rdata_q;
    assign ram_a       = ram_a_q;
    assign ram_wr      = ram_wr_q;
    assign ram_dout    = ram_dout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_ack;
    logic [1:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stallreq_if, stallreq_mem;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // environment RAM and reference memory image
    logic [7:0]  ram_arr [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    // scoreboard queues
    logic [31:0] exp_if_q[$];
    logic [32:0] exp_mem_q[$];   // {is_load, data}
    logic [39:0] exp_wr_q[$];    // {addr, byte}

    // per-transaction traces indexed by cycles since request
    logic [31:0] if_tr_a [64];
    logic [31:0] mem_tr_a [64];
    logic        mem_tr_wr [64];
    logic [7:0]  mem_tr_dout [64];

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_arr.exists(a)) return ram_arr[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
        logic [31:0] d;
        d = 32'd0;
        for (int k = 0; k < n; k++) begin
            d = d | ({24'd0, ref_rd(addr + 32'(k))} << (8 * k));
        end
        return d;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram_arr[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_a"}, ram_a, 0);
        check({tag, "_ram_wr"}, ram_wr, 0);
        check({tag, "_ram_dout"}, ram_dout, 0);
        check({tag, "_if_ack"}, if_ack, 0);
        check({tag, "_if_data"}, if_data, 0);
        check({tag, "_mem_ack"}, mem_ack, 0);
        check({tag, "_mem_rdata"}, mem_rdata, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- synchronous RAM ----------------
    always @(posedge clk) begin
        if (ram_wr) ram_arr[ram_a] = ram_dout;
        ram_din <= ram_rd(ram_a);
    end

    // ---------------- monitor ----------------
    logic [32:0] mon_e;
    always @(negedge clk) begin
        if (rst) begin
            if (if_ack) begin
                if (exp_if_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL if_ack_unexpected: got ack data %h, required no ack", if_data);
                end else begin
                    check("if_data", if_data, exp_if_q.pop_front());
                end
            end
            if (mem_ack) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mem_ack_unexpected: got ack data %h, required no ack", mem_rdata);
                end else begin
                    mon_e = exp_mem_q.pop_front();
                    if (mon_e[32]) check("mem_rdata", mem_rdata, mon_e[31:0]);
                end
            end
            if (ram_wr) begin
                if (exp_wr_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL ram_wr_unexpected: got write a=%h d=%h, required none", ram_a, ram_dout);
                end else begin
                    check("ram_write", {ram_a, ram_dout}, exp_wr_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_mem(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        int  n;
        bit  done;
        n = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                exp_wr_q.push_back({addr + 32'(k), wdata[8*k +: 8]});
                ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
            end
            exp_mem_q.push_back({1'b0, 32'd0});
        end else begin
            exp_mem_q.push_back({1'b1, model_load(addr, n)});
        end
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wdata;
        lat = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (lat < 64) begin
                mem_tr_a[lat] = ram_a; mem_tr_wr[lat] = ram_wr; mem_tr_dout[lat] = ram_dout;
            end
            if (lat == 0) check("stallreq_mem_wait", stallreq_mem, 1);
            if (mem_ack) begin
                check("stallreq_mem_ack", stallreq_mem, 0);
                done = 1'b1;
            end else begin
                lat++;
                if (lat > 40) begin
                    n_checks++; n_errors++;
                    $display("FAIL mem_ack_timeout: got no ack in 40 cycles, required ack");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] addr, output int lat);
        bit done;
        exp_if_q.push_back(model_load(addr, 4));
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        lat = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (lat < 64) if_tr_a[lat] = ram_a;
            if (lat == 0 && !mem_req) check("stallreq_if_wait", stallreq_if, 1);
            if (if_ack) begin
                check("stallreq_if_ack", stallreq_if, 0);
                done = 1'b1;
            end else begin
                lat++;
                if (lat > 40) begin
                    n_checks++; n_errors++;
                    $display("FAIL if_ack_timeout: got no ack in 40 cycles, required ack");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat_a, lat_b, nwr;
        bit done;
        logic [31:0] a, w;
        logic [1:0]  sel;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // word fetch, cycle-exact addresses
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        do_if(32'h100, lat_a);
        check("fetch_lat", lat_a, 6);
        for (int k = 1; k <= 4; k++) check("fetch_ram_a", if_tr_a[k], 32'h100 + 32'(k - 1));
        @(negedge clk);
        check("fetch_hold_if_data", if_data, 32'h00100513);

        // byte store
        do_mem(1'b1, 2'b00, 32'h20, 32'hAABBCCDD, lat_b);
        check("bstore_lat", lat_b, 2);
        nwr = 0;
        for (int k = 0; k <= lat_b; k++) nwr += int'(mem_tr_wr[k]);
        check("bstore_wr_cycles", nwr, 1);
        check("bstore_wr_g1", mem_tr_wr[1], 1);
        check("bstore_ram_a", mem_tr_a[1], 32'h20);
        check("bstore_dout", mem_tr_dout[1], 8'hDD);

        // contention: half load vs fetch
        preload(32'h40, 8'h34); preload(32'h41, 8'h12);
        fork
            do_if(32'h600, lat_a);
            do_mem(1'b0, 2'b01, 32'h40, 32'd0, lat_b);
        join
        check("cont_mem_lat", lat_b, 4);
        check("cont_if_lat", lat_a, 11);
        check("cont_mem_rdata_hold", mem_rdata, 32'h00001234);

        // flush of an in-flight fetch, then a new fetch granted right away
        exp_if_q.push_back(model_load(32'h300, 4));
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1 if_flush = 1'b1;
        @(negedge clk);
        check("flush_stallreq_if", stallreq_if, 0);
        check("flush_state_read", dbg_state, 1);
        @(posedge clk); #1 if_flush = 1'b0; if_addr = 32'h300;
        @(negedge clk);
        check("flush_state_idle", dbg_state, 0);
        lat_a = 0; done = 1'b0;
        while (!done) begin
            if (if_ack) done = 1'b1;
            else begin
                @(negedge clk); lat_a++;
                if (lat_a > 40) begin
                    n_checks++; n_errors++;
                    $display("FAIL flush_refetch_timeout: got no ack, required ack");
                    done = 1'b1;
                end
            end
        end
        check("flush_refetch_lat", lat_a, 6);
        @(posedge clk); #1 if_req = 1'b0;

        // wrap-around store and load
        do_mem(1'b1, 2'b10, 32'hFFFFFFFE, 32'h44332211, lat_b);
        check("wrap_lat", lat_b, 5);
        check("wrap_a0", mem_tr_a[1], 32'hFFFFFFFE);
        check("wrap_a1", mem_tr_a[2], 32'hFFFFFFFF);
        check("wrap_a2", mem_tr_a[3], 32'h00000000);
        check("wrap_a3", mem_tr_a[4], 32'h00000001);
        do_mem(1'b0, 2'b11, 32'hFFFFFFFE, 32'd0, lat_b);
        check("wrap_load_lat", lat_b, 6);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 7))
                                            : 32'h1000 + 32'($urandom_range(0, 63));
            w = $urandom;
            sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    do_if(a, lat_a);
                    check("rand_if_lat", lat_a, 6);
                end
                1: begin
                    do_mem(1'b0, sel, a, w, lat_b);
                    check("rand_load_lat", lat_b, (sel == 2'b00) ? 3 : (sel == 2'b01) ? 4 : 6);
                end
                default: begin
                    do_mem(1'b1, sel, a, w, lat_b);
                    check("rand_store_lat", lat_b, (sel == 2'b00) ? 2 : (sel == 2'b01) ? 3 : 5);
                end
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // reset in the middle of a word store: only byte 0 reaches the RAM
        exp_wr_q.push_back({32'h500, 8'h11});
        ref_mem[32'h500] = 8'h11;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'b10; mem_addr = 32'h500; mem_wdata = 32'h44332211;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("rst_async_ram_wr", ram_wr, 0);
        mem_req = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("after_mid_reset");
        check("rst_ram_byte0", ram_rd(32'h500), 8'h11);
        check("rst_ram_byte1_untouched", ram_rd(32'h501), init_byte(32'h501));

        repeat (5) @(negedge clk);
        check("left_if_q", exp_if_q.size(), 0);
        check("left_mem_q", exp_mem_q.size(), 0);
        check("left_wr_q", exp_wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
